// File: rtl/vram_wr_arbiter.sv
// vram_wr_arbiter
// Shares the single VRAM port-B write path between the pixel-write engines
// (0 = clear engine, 1 = line rasterizer, 2 = spare). Grants rotate
// round-robin. A requester may keep the port for a bounded burst while others
// wait, so a long clear sweep cannot starve the rasterizer. Every accepted
// beat appears on the VRAM port exactly one cycle later. A fence handshake
// lets the swap logic stop new grants and wait for the last write to land.
//
// Ports
//   CLK          system clock
//   rst          asynchronous active-high reset
//   req_valid    per-requester write request
//   req_addr     packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_data     packed pixel bytes, requester i at [i*8 +: 8]
//   req_ready    one-hot-or-zero grant (combinational)
//   fence_req    level; while high no new grants are issued
//   fence_ack    registered; high once the fence is up and nothing is in flight
//   vram_addr_b  registered VRAM address
//   vram_data_b  registered VRAM data
//   vram_we_b    registered VRAM write enable
//   busy         any request pending or a write on the port
module vram_wr_arbiter #(
   parameter int NUM_REQ   = 3,
   parameter int ADDR_W    = 18,
   parameter int MAX_BURST = 16
) (
   input  logic                      CLK,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*8-1:0]      req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic                      fence_req,
   output logic                      fence_ack,
   output logic [ADDR_W-1:0]         vram_addr_b,
   output logic [7:0]                vram_data_b,
   output logic                      vram_we_b,
   output logic                      busy
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BURST - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

   logic [IDX_W-1:0]   owner;
   logic [IDX_W-1:0]   last;
   logic [CNT_W-1:0]   burst_cnt;
   logic [IDX_W-1:0]   winner;
   logic               grant_any;
   logic               others_valid;
   logic               hold;
   logic [NUM_REQ-1:0] owner_mask;

   // Winner selection. The current owner keeps the port while it still has
   // burst budget, or indefinitely when nobody else is asking. Otherwise the
   // scan starts just past the most recent winner, which gives round-robin
   // order and lets a requester that dropped out mid-burst be skipped cleanly.
   // A raised fence masks the grant in the same cycle.
   always_comb begin
      owner_mask        = '0;
      owner_mask[owner] = 1'b1;
      others_valid      = |(req_valid & ~owner_mask);
      hold              = req_valid[owner] && ((burst_cnt < CNT_MAX) || !others_valid);
      winner            = owner;
      grant_any         = 1'b0;
      if (hold) begin
         grant_any = 1'b1;
      end else begin
         for (int k = 1; k <= NUM_REQ; k++) begin
            if (!grant_any && req_valid[(int'(last) + k) % NUM_REQ]) begin
               winner    = IDX_W'((int'(last) + k) % NUM_REQ);
               grant_any = 1'b1;
            end
         end
      end
      if (fence_req) begin
         grant_any = 1'b0;
      end
      req_ready = '0;
      if (grant_any) begin
         req_ready[winner] = 1'b1;
      end
   end

   // Output register and arbitration state. A grant is only ever given to a
   // valid requester, so grant_any is exactly "a beat transfers this cycle".
   // The burst counter saturates so a sole requester is never throttled, and
   // the cap only bites again once someone else shows up.
   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         vram_addr_b <= '0;
         vram_data_b <= '0;
         vram_we_b   <= 1'b0;
         fence_ack   <= 1'b0;
         owner       <= '0;
         last        <= LAST_IDX;
         burst_cnt   <= '0;
      end else begin
         fence_ack <= fence_req & ~vram_we_b;
         vram_we_b <= grant_any;
         if (grant_any) begin
            vram_addr_b <= req_addr[int'(winner)*ADDR_W +: ADDR_W];
            vram_data_b <= req_data[int'(winner)*8 +: 8];
            last        <= winner;
            if (winner == owner) begin
               if (burst_cnt != CNT_MAX) begin
                  burst_cnt <= burst_cnt + CNT_W'(1);
               end
            end else begin
               owner     <= winner;
               burst_cnt <= '0;
            end
         end
      end
   end

   assign busy = (|req_valid) | vram_we_b;

endmodule

// File: tb/tb_vram_wr_arbiter.sv
// tb_vram_wr_arbiter
// Self-checking bench for vram_wr_arbiter. Inputs change on the falling edge
// and everything is sampled 2 time units later, well clear of the rising
// edge. A monitor pushes every observed transfer into a scoreboard queue and
// pops it when the registered write appears on the VRAM port. Scenario tasks
// check grant order and fence timing inline. A second instance built with
// MAX_BURST=1 exercises plain round-robin rotation.
module tb_vram_wr_arbiter;

   localparam int NUM_REQ = 3;
   localparam int ADDR_W  = 18;

   typedef struct packed {
      logic [ADDR_W-1:0] a;
      logic [7:0]        d;
   } wr_t;

   logic                      CLK = 1'b0;
   logic                      rst = 1'b1;
   logic [NUM_REQ-1:0]        req_valid = '0;
   logic                      fence_req = 1'b0;
   logic [ADDR_W-1:0]         addr_v [NUM_REQ];
   logic [7:0]                data_v [NUM_REQ];
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*8-1:0]      req_data;

   logic [NUM_REQ-1:0] req_ready;
   logic               fence_ack;
   logic [ADDR_W-1:0]  vram_addr_b;
   logic [7:0]         vram_data_b;
   logic               vram_we_b;
   logic               busy;

   logic [NUM_REQ-1:0] r1_ready;
   logic               r1_ack;
   logic [ADDR_W-1:0]  r1_addr;
   logic [7:0]         r1_data;
   logic               r1_we;
   logic               r1_busy;

   wr_t sb [$];
   wr_t exp_wr;
   int  n_vec  = 0;
   int  n_fail = 0;

   assign req_addr = {addr_v[2], addr_v[1], addr_v[0]};
   assign req_data = {data_v[2], data_v[1], data_v[0]};

   vram_wr_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .MAX_BURST(16)) dut (
      .CLK(CLK), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
      .req_data(req_data), .req_ready(req_ready), .fence_req(fence_req),
      .fence_ack(fence_ack), .vram_addr_b(vram_addr_b), .vram_data_b(vram_data_b),
      .vram_we_b(vram_we_b), .busy(busy)
   );

   vram_wr_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .MAX_BURST(1)) dut_rr (
      .CLK(CLK), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
      .req_data(req_data), .req_ready(r1_ready), .fence_req(fence_req),
      .fence_ack(r1_ack), .vram_addr_b(r1_addr), .vram_data_b(r1_data),
      .vram_we_b(r1_we), .busy(r1_busy)
   );

   always #5 CLK = ~CLK;

   // Anything accepted just before an async reset must never reach the port.
   always @(posedge rst) sb.delete();

   // Scoreboard: a write must appear exactly one cycle after each transfer,
   // with that transfer's address and data, and never otherwise.
   always @(negedge CLK) begin
      #2;
      if (rst) begin
         sb.delete();
      end else begin
         n_vec++;
         if (vram_we_b !== (sb.size() > 0)) begin
            n_fail++;
            $display("[TB] FAIL write_enable: got %0b, want %0b", vram_we_b, sb.size() > 0);
         end else if (vram_we_b) begin
            exp_wr = sb.pop_front();
            n_vec++;
            if ({vram_addr_b, vram_data_b} !== exp_wr) begin
               n_fail++;
               $display("[TB] FAIL write_payload: got %0h/%0h, want %0h/%0h",
                        vram_addr_b, vram_data_b, exp_wr.a, exp_wr.d);
            end
         end
         n_vec++;
         if (!$onehot0(req_ready) || (fence_req && req_ready != '0)) begin
            n_fail++;
            $display("[TB] FAIL ready_legal: got %b with fence %b", req_ready, fence_req);
         end
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && req_ready[i]) sb.push_back({addr_v[i], data_v[i]});
         end
      end
   end

   task automatic do_reset();
      @(negedge CLK);
      rst       = 1'b1;
      req_valid = '0;
      fence_req = 1'b0;
      @(negedge CLK);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      fence_req = 1'b1;
      repeat (2) @(negedge CLK);
      #2;
      n_vec++;
      if ({vram_we_b, fence_ack, busy, req_ready} !== 6'b0 || vram_addr_b !== '0 || vram_data_b !== 8'h00) begin
         n_fail++;
         $display("[TB] FAIL reset_state: got we=%b ack=%b busy=%b rdy=%b addr=%0h data=%0h, want all zero",
                  vram_we_b, fence_ack, busy, req_ready, vram_addr_b, vram_data_b);
      end
      @(negedge CLK);
      fence_req = 1'b0;
      rst       = 1'b0;
   endtask

   task automatic test_single();
      for (int i = 0; i < 40; i++) begin
         @(negedge CLK);
         req_valid = 3'b001;
         addr_v[0] = ADDR_W'(i);
         data_v[0] = 8'h5A;
         #2;
         n_vec++;
         if (req_ready !== 3'b001 || busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL single_grant[%0d]: got rdy=%b busy=%b, want 001/1", i, req_ready, busy);
         end
      end
      @(negedge CLK);
      req_valid = '0;
      #2;
      n_vec++;
      if (req_ready !== 3'b000 || vram_we_b !== 1'b1 || vram_addr_b !== ADDR_W'(39)) begin
         n_fail++;
         $display("[TB] FAIL single_tail: got rdy=%b we=%b addr=%0h, want 000/1/27", req_ready, vram_we_b, vram_addr_b);
      end
      @(negedge CLK);
   endtask

   // From reset the owner is already 0 with burst_cnt 0, so the opening hold
   // counts toward the budget: req 0 gets 15 grants first, then the two
   // requesters alternate in runs of 16.
   task automatic test_burst_cap();
      logic [NUM_REQ-1:0] want;
      do_reset();
      for (int i = 0; i < 15 + 16*3; i++) begin
         @(negedge CLK);
         req_valid = 3'b011;
         addr_v[0] = ADDR_W'(i*4);
         addr_v[1] = ADDR_W'(i*4 + 1);
         data_v[0] = 8'(i);
         data_v[1] = 8'(i + 8'h80);
         if (i < 15) want = 3'b001;
         else want = (((i - 15) / 16) % 2 == 0) ? 3'b010 : 3'b001;
         #2;
         n_vec++;
         if (req_ready !== want) begin
            n_fail++;
            $display("[TB] FAIL burst_grant[%0d]: got %b, want %b", i, req_ready, want);
         end
      end
      @(negedge CLK);
      req_valid = '0;
      @(negedge CLK);
   endtask

   task automatic test_rr_wrap();
      int seq [10];
      for (int k = 0; k < 6; k++) seq[k] = k % 3;
      for (int k = 6; k < 10; k++) seq[k] = (k % 2) * 2;
      do_reset();
      for (int r = 0; r < NUM_REQ; r++) begin
         addr_v[r] = ADDR_W'(18'h100 + r);
         data_v[r] = 8'(r + 1);
      end
      for (int k = 0; k < 10; k++) begin
         @(negedge CLK);
         req_valid = (k < 6) ? 3'b111 : 3'b101;
         #2;
         n_vec++;
         if (r1_ready !== 3'(1 << seq[k]) || r1_busy !== 1'b1 || r1_ack !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL rr_grant[%0d]: got %b busy=%b ack=%b, want %b/1/0",
                     k, r1_ready, r1_busy, r1_ack, 3'(1 << seq[k]));
         end
         if (k > 0) begin
            n_vec++;
            if (r1_we !== 1'b1 || r1_addr !== ADDR_W'(18'h100 + seq[k-1]) || r1_data !== 8'(seq[k-1] + 1)) begin
               n_fail++;
               $display("[TB] FAIL rr_write[%0d]: got we=%b addr=%0h data=%0h, want 1/%0h/%0h",
                        k, r1_we, r1_addr, r1_data, 18'h100 + seq[k-1], seq[k-1] + 1);
            end
         end
      end
      @(negedge CLK);
      req_valid = '0;
      @(negedge CLK);
   endtask

   task automatic test_fence_inflight();
      logic [NUM_REQ-1:0] want_rdy [7];
      logic               want_ack [7];
      want_rdy = '{3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b000};
      want_ack = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      do_reset();
      addr_v[1] = 18'h3AA;
      data_v[1] = 8'h77;
      for (int c = 0; c < 7; c++) begin
         @(negedge CLK);
         req_valid = (c < 6) ? 3'b010 : 3'b000;
         fence_req = (c >= 1 && c <= 4);
         #2;
         n_vec++;
         if (req_ready !== want_rdy[c] || fence_ack !== want_ack[c]) begin
            n_fail++;
            $display("[TB] FAIL fence_busy[t+%0d]: got rdy=%b ack=%b, want %b/%b",
                     c, req_ready, fence_ack, want_rdy[c], want_ack[c]);
         end
      end
      @(negedge CLK);
   endtask

   task automatic test_fence_idle();
      logic want_ack [4];
      want_ack = '{1'b0, 1'b1, 1'b1, 1'b0};
      for (int c = 0; c < 4; c++) begin
         @(negedge CLK);
         req_valid = '0;
         fence_req = (c < 2);
         #2;
         n_vec++;
         if (fence_ack !== want_ack[c] || busy !== 1'b0 || req_ready !== 3'b000) begin
            n_fail++;
            $display("[TB] FAIL fence_idle[t+%0d]: got ack=%b busy=%b rdy=%b, want %b/0/000",
                     c, fence_ack, busy, req_ready, want_ack[c]);
         end
      end
   endtask

   task automatic test_reset_midburst();
      do_reset();
      for (int k = 0; k < 5; k++) begin
         @(negedge CLK);
         req_valid = 3'b011;
         addr_v[0] = ADDR_W'(18'h200 + k);
         data_v[0] = 8'hC0;
      end
      @(posedge CLK);
      #2;
      n_vec++;
      if (vram_we_b !== 1'b1 || vram_addr_b !== 18'h204) begin
         n_fail++;
         $display("[TB] FAIL midburst_write: got we=%b addr=%0h, want 1/204", vram_we_b, vram_addr_b);
      end
      rst = 1'b1;
      #1;
      n_vec++;
      if (vram_we_b !== 1'b0 || fence_ack !== 1'b0 || vram_addr_b !== '0) begin
         n_fail++;
         $display("[TB] FAIL async_reset: got we=%b ack=%b addr=%0h, want 0/0/0", vram_we_b, fence_ack, vram_addr_b);
      end
      @(negedge CLK);
      rst       = 1'b0;
      req_valid = 3'b111;
      #2;
      n_vec++;
      if (req_ready !== 3'b001) begin
         n_fail++;
         $display("[TB] FAIL post_reset_grant: got %b, want 001", req_ready);
      end
      @(negedge CLK);
      req_valid = '0;
      repeat (2) @(negedge CLK);
   endtask

   initial begin
      for (int r = 0; r < NUM_REQ; r++) begin
         addr_v[r] = '0;
         data_v[r] = '0;
      end
      $display("[TB] start");
      test_reset();
      test_single();
      test_burst_cap();
      test_rr_wrap();
      test_fence_inflight();
      test_fence_idle();
      test_reset_midburst();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
